alu_issue_pipe: RTL
===================

# alu_issue_pipe

Pipelined issue and result-buffering stage wrapped around the combinational 16-bit ALU (Chip_Alu). It accepts operand/opcode requests over a valid/ready handshake, holds them in a register stage that drives the ALU inputs, and captures each ALU result and carry into a small FIFO. The FIFO presents results to the downstream consumer over a second valid/ready handshake. It also keeps operation and carry statistics for debug readout.

## Interface
- WIDTH, 16, operand/result width; matches ALU a/b/result
- SEL_W, 4, opcode width; matches ALU sel
- DEPTH, 4, result FIFO entries; power of 2, ≥2
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept request this cycle
- in_a, in_b  in  WIDTH  operands
- in_sel  in  SEL_W  ALU opcode, passed through unmodified
- alu_a, alu_b  out  WIDTH  registered operands to ALU a/b
- alu_sel  out  SEL_W  registered opcode to ALU sel
- alu_result  in  WIDTH  ALU result (combinational from alu_*)
- alu_carry  in  1  ALU Carry_out
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer takes head this cycle
- out_result  out  WIDTH  head result
- out_carry  out  1  head carry
- out_sel  out  SEL_W  opcode that produced head result
- op_count  out  16  completed ops, wraps mod 2^16
- carry_count  out  16  completed ops with carry=1, saturates at 16'hFFFF

## Operation
- Stage 1 (operand register): s1_valid flag plus alu_a/alu_b/alu_sel. Load on accept = in_valid && in_ready; otherwise hold values (stall keeps ALU inputs stable).
- Stage 2 (capture): push = s1_valid && fifo_space, where fifo_space = (count < DEPTH) || pop. Push writes {alu_result, alu_carry, alu_sel} at wr_ptr.
- in_ready = !s1_valid || push (combinational; depends on out_ready through pop).
- s1_valid next = accept ? 1 : (push ? 0 : s1_valid).
- FIFO: pop = out_valid && out_ready. count updates +1 on push only, -1 on pop only, unchanged on both. Pointers are log2(DEPTH) bits and wrap naturally.
- out_valid = (count != 0). out_* are driven from the head entry (register array read). There is no empty-FIFO bypass.
- The block is opcode-agnostic: sel is never decoded, and result/carry are stored exactly as the ALU drives them.
- Statistics update on push: op_count += 1 (wraps). carry_count += 1 when alu_carry = 1, held at FFFF once reached.
- Reset value of every output: in_ready=1 (s1 empty), alu_a=alu_b=0, alu_sel=0, out_valid=0, out_result=0, out_carry=0, out_sel=0, op_count=0, carry_count=0. Reset also clears pointers and count. FIFO array contents are don't-care, but out_* must read 0 while count=0.

## Timing
- Latency: request accepted at edge N → alu_* valid after N → pushed at edge N+1 → out_valid high after N+1 (2 cycles accept-to-output).
- Throughput: 1 request/cycle while out_ready stays high.
- FIFO full with simultaneous pop: push is permitted, count stays DEPTH, and in_ready may stay high.
- FIFO full without pop: s1 stalls holding alu_*, and in_ready=0 only while s1_valid=1. Total buffering is DEPTH+1 requests.
- Empty FIFO with push and out_ready=1: no pop that cycle; the result appears next cycle.
- Reset asserted mid-operation: at the next edge, all in-flight requests and buffered results are discarded and outputs take their reset values. rst dominates accept, push and pop.
- in_* are sampled only on accept. out_* must stay stable while out_valid && !out_ready.

## Test plan
- Stub ALU computes {carry, result} = a+b. Send a=10, b=6 → out_valid exactly 2 cycles after accept, out_result=16, out_carry=0, out_sel=0000, op_count=1.
- Overflow: a=16'hFFFF, b=1, sel=0011 → out_result=0, out_carry=1, out_sel=0011, carry_count=1.
- Backpressure: out_ready=0, issue 6 back-to-back requests → exactly 5 accepted, in_ready=0 after the 5th, count=4. Then out_ready=1 → results drain in issue order with no loss or duplication.
- Full + simultaneous pop: FIFO full, out_ready=1, in_valid=1 continuously → one accept and one output per cycle, count stays 4.
- Reset mid-stream: 3 results buffered plus s1 occupied, pulse rst one cycle → out_valid=0, in_ready=1, counters=0; the next request (200, 100) yields 300 after 2 cycles.
- Counter saturation: force 65536 carry-producing ops (or preload via hierarchical force) → carry_count holds FFFF, op_count wraps to 0.

Source files
------------

// File: rtl/alu_issue_pipe.sv
// Issue/capture stage around a combinational ALU: one operand register stage
// feeding the ALU, then a small result FIFO with operation/carry statistics.
module alu_issue_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SEL_W-1:0] in_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic [SEL_W-1:0] out_sel,
    output logic [15:0]      op_count,
    output logic [15:0]      carry_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = WIDTH + 1 + SEL_W;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      op_count_q, op_count_d;
    logic [15:0]      carry_count_q, carry_count_d;

    logic             accept, push, pop, fifo_space;
    logic [ENT_W-1:0] head;

    // Handshake decisions; a pop frees a slot in the same cycle so a full FIFO keeps streaming.
    always_comb begin
        pop        = (count_q != '0) && out_ready;
        fifo_space = (count_q < CNT_W'(DEPTH)) || pop;
        push       = s1_valid_q && fifo_space;
        in_ready   = !s1_valid_q || push;
        accept     = in_valid && in_ready;
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        a_d           = a_q;
        b_d           = b_q;
        sel_d         = sel_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        op_count_d    = op_count_q;
        carry_count_d = carry_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            b_d        = in_b;
            sel_d      = in_sel;
        end else if (push) begin
            s1_valid_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            op_count_d = op_count_q + 16'd1;
            if (alu_carry && (carry_count_q != 16'hFFFF)) begin
                carry_count_d = carry_count_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            sel_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            op_count_q    <= '0;
            carry_count_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sel_q         <= sel_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            op_count_q    <= op_count_d;
            carry_count_q <= carry_count_d;
        end
    end

    // Result storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {alu_result, alu_carry, sel_q};
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_valid  = (count_q != '0);
        out_result = out_valid ? head[ENT_W-1 -: WIDTH] : '0;
        out_carry  = out_valid ? head[SEL_W] : 1'b0;
        out_sel    = out_valid ? head[SEL_W-1:0] : '0;
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_sel     = sel_q;
    assign op_count    = op_count_q;
    assign carry_count = carry_count_q;

endmodule
